// File: rtl/thor2023_irq_pkg.sv
// Shared types and constants for the Thor2023 interrupt router.
// Queue entries carry level and cause; the offer slot uses a two-state FSM.
package thor2023_irq_pkg;

   localparam logic [3:0] IRQ_LVL_NMI = 4'd15;

   typedef struct packed {
      logic [3:0] level;
      logic [7:0] cause;
   } irq_msg_t;

   localparam int MSG_W = $bits(irq_msg_t);

   typedef enum logic {
      OFFER_IDLE  = 1'b0,
      OFFER_VALID = 1'b1
   } offer_state_t;

   // Level 15 ignores the core's priority mask.
   function automatic logic lvl_unmasked(input logic [3:0] level, input logic [3:0] ipl);
      return (level > ipl) || (level == IRQ_LVL_NMI);
   endfunction

endpackage

// File: rtl/thor2023_irq_fifo.sv
// Per-core pending queue of irq messages; a push into a full queue succeeds
// only when the same edge also pops.
module thor2023_irq_fifo
   import thor2023_irq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [MSG_W-1:0] data_i,
   output logic [MSG_W-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   irq_msg_t        mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      pop_ok   = pop_i && !empty_o;
      push_ok  = push_i && (!full_o || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= irq_msg_t'(data_i);
      end
   end

endmodule

// File: rtl/thor2023_irq_router.sv
// Converts the PIC's held prioritized request into exactly-once deliveries
// on per-core irq/cause ports, with per-core queues, masking and ack.
module thor2023_irq_router
   import thor2023_irq_pkg::*;
#(
   parameter int NCORES = 4,
   parameter int QDEPTH = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [3:0]          irq_i,
   input  logic [7:0]          cause_i,
   input  logic [5:0]          core_i,
   input  logic                nmi_i,
   input  logic [4*NCORES-1:0] ipl_i,
   input  logic [NCORES-1:0]   ack_i,
   output logic [4*NCORES-1:0] irq_o,
   output logic [8*NCORES-1:0] cause_o,
   output logic [NCORES-1:0]   nmi_o,
   output logic [NCORES-1:0]   ovf_o,
   output logic                misroute_o
);

   localparam logic [5:0] NCORES_L = 6'(NCORES);

   // Handshake: core c sees a request while irq_o[c] != 0; ack_i[c] high at
   // a clock edge in that state consumes it, and irq_o[c] drops at that edge.

   logic [17:0]       tuple;
   logic [17:0]       lt_q, lt_d;
   logic              new_req;
   logic              misroute_req;
   logic [5:0]        tgt;
   logic [MSG_W-1:0]  msg;
   logic [NCORES-1:0] push;
   logic [NCORES-1:0] pop_v;
   logic [NCORES-1:0] full_v;
   logic [NCORES-1:0] ovf_q, ovf_d;
   logic              misroute_q, misroute_d;
   logic              nmi_q, nmi_d;

   assign tuple = {irq_i, cause_i, core_i};
   assign msg   = {irq_i, cause_i};

   always_comb begin
      new_req      = (irq_i != 4'd0) && (tuple != lt_q);
      // A held request matches lt and is ignored; dropping irq_i re-arms capture.
      lt_d         = (irq_i == 4'd0) ? '0 : (new_req ? tuple : lt_q);
      misroute_req = new_req && (core_i >= NCORES_L);
      tgt          = misroute_req ? 6'd0 : core_i;
      misroute_d   = misroute_q | misroute_req;
      nmi_d        = nmi_i;
      push         = '0;
      ovf_d        = ovf_q;
      for (int c = 0; c < NCORES; c++) begin
         push[c]  = new_req && (tgt == 6'(c));
         ovf_d[c] = ovf_q[c] | (push[c] & full_v[c] & ~pop_v[c]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lt_q       <= '0;
         ovf_q      <= '0;
         misroute_q <= 1'b0;
         nmi_q      <= 1'b0;
      end else begin
         lt_q       <= lt_d;
         ovf_q      <= ovf_d;
         misroute_q <= misroute_d;
         nmi_q      <= nmi_d;
      end
   end

   assign ovf_o      = ovf_q;
   assign misroute_o = misroute_q;
   assign nmi_o      = {NCORES{nmi_q}};

   for (genvar c = 0; c < NCORES; c++) begin : g_core
      offer_state_t     offer_state_q, offer_state_d;
      irq_msg_t         slot_q, slot_d;
      logic [MSG_W-1:0] head;
      logic             empty;
      logic             visible;

      thor2023_irq_fifo #(
         .DEPTH (QDEPTH)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .push_i  (push[c]),
         .pop_i   (pop_v[c]),
         .data_i  (msg),
         .head_o  (head),
         .full_o  (full_v[c]),
         .empty_o (empty)
      );

      // The slot is a copy of the queue head; the queue pops only on ack.
      assign visible  = (offer_state_q == OFFER_VALID) &&
                        lvl_unmasked(slot_q.level, ipl_i[4*c +: 4]);
      assign pop_v[c] = visible && ack_i[c];

      always_comb begin
         offer_state_d = offer_state_q;
         slot_d        = slot_q;
         case (offer_state_q)
            OFFER_IDLE: begin
               if (!empty) begin
                  offer_state_d = OFFER_VALID;
                  slot_d        = irq_msg_t'(head);
               end
            end
            OFFER_VALID: begin
               if (pop_v[c]) begin
                  offer_state_d = OFFER_IDLE;
               end
            end
         endcase
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            offer_state_q <= OFFER_IDLE;
            slot_q        <= '0;
         end else begin
            offer_state_q <= offer_state_d;
            slot_q        <= slot_d;
         end
      end

      assign irq_o[4*c +: 4]   = visible ? slot_q.level : 4'd0;
      assign cause_o[8*c +: 8] = (offer_state_q == OFFER_VALID) ? slot_q.cause : 8'd0;
   end

endmodule

// File: tb/tb_thor2023_irq_router.sv
// Randomized and directed bench for thor2023_irq_router against a queue-level
// reference model, with a delivery scoreboard per core.
module tb_thor2023_irq_router;

   localparam int NC = 4;
   localparam int QD = 4;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b1;
   logic [3:0]      irq_i = '0;
   logic [7:0]      cause_i = '0;
   logic [5:0]      core_i = '0;
   logic            nmi_i = 1'b0;
   logic [4*NC-1:0] ipl_i = '0;
   logic [NC-1:0]   ack_i = '0;
   logic [4*NC-1:0] irq_o;
   logic [8*NC-1:0] cause_o;
   logic [NC-1:0]   nmi_o;
   logic [NC-1:0]   ovf_o;
   logic            misroute_o;

   always #5 clk_i = ~clk_i;

   thor2023_irq_router #(
      .NCORES (NC),
      .QDEPTH (QD)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .irq_i      (irq_i),
      .cause_i    (cause_i),
      .core_i     (core_i),
      .nmi_i      (nmi_i),
      .ipl_i      (ipl_i),
      .ack_i      (ack_i),
      .irq_o      (irq_o),
      .cause_o    (cause_o),
      .nmi_o      (nmi_o),
      .ovf_o      (ovf_o),
      .misroute_o (misroute_o)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int deliv [NC];

   // Reference model: pend_q holds every undelivered entry, head first;
   // off_m marks that the head is currently on offer.
   logic [11:0]   pend_q [NC][$];
   logic [11:0]   exp_q  [NC][$];
   logic          off_m  [NC];
   logic [17:0]   lt_m = '0;
   logic          nmi_m = 1'b0;
   logic          mis_m = 1'b0;
   logic [NC-1:0] ovf_m = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] m_irq(input int c);
      logic [3:0] lvl;
      logic [3:0] ipl;
      if (!off_m[c] || pend_q[c].size() == 0) return 4'd0;
      lvl = pend_q[c][0][11:8];
      ipl = ipl_i[4*c +: 4];
      return ((lvl > ipl) || (lvl == 4'd15)) ? lvl : 4'd0;
   endfunction

   function automatic logic [7:0] m_cause(input int c);
      if (!off_m[c] || pend_q[c].size() == 0) return 8'd0;
      return pend_q[c][0][7:0];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         pend_q[c].delete();
         exp_q[c].delete();
         off_m[c] = 1'b0;
      end
      lt_m  = '0;
      nmi_m = 1'b0;
      mis_m = 1'b0;
      ovf_m = '0;
   endtask

   task automatic model_step();
      logic [17:0] tup;
      logic        nw;
      logic        pop;
      int          tgt;
      int          had;
      tup  = {irq_i, cause_i, core_i};
      nw   = (irq_i != 4'd0) && (tup != lt_m);
      lt_m = (irq_i == 4'd0) ? 18'd0 : tup;
      tgt  = (int'(core_i) < NC) ? int'(core_i) : 0;
      if (nw && int'(core_i) >= NC) mis_m = 1'b1;
      for (int c = 0; c < NC; c++) begin
         pop = (m_irq(c) != 4'd0) && ack_i[c];
         had = pend_q[c].size();
         if (pop) begin
            void'(pend_q[c].pop_front());
            off_m[c] = 1'b0;
         end else if (!off_m[c] && had > 0) begin
            off_m[c] = 1'b1;
         end
         if (nw && tgt == c) begin
            if (had < QD || pop) begin
               pend_q[c].push_back({irq_i, cause_i});
               exp_q[c].push_back({irq_i, cause_i});
            end else begin
               ovf_m[c] = 1'b1;
            end
         end
      end
      nmi_m = nmi_i;
   endtask

   // Monitor: compares outputs mid-cycle, scores deliveries, then advances the model.
   always @(negedge clk_i) begin
      if (!rst_ni) model_reset();
      for (int c = 0; c < NC; c++) begin
         if (rst_ni && ack_i[c] && irq_o[4*c +: 4] != 4'd0) begin
            deliv[c]++;
            if (exp_q[c].size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL deliver core%0d: got %0h expected none", c,
                        {irq_o[4*c +: 4], cause_o[8*c +: 8]});
            end else begin
               chk($sformatf("deliver core%0d", c),
                   {20'd0, irq_o[4*c +: 4], cause_o[8*c +: 8]}, {20'd0, exp_q[c].pop_front()});
            end
         end
         chk($sformatf("irq_o core%0d", c), {28'd0, irq_o[4*c +: 4]}, {28'd0, m_irq(c)});
         chk($sformatf("cause_o core%0d", c), {24'd0, cause_o[8*c +: 8]}, {24'd0, m_cause(c)});
      end
      chk("ovf_o", {28'd0, ovf_o}, {28'd0, ovf_m});
      chk("misroute_o", {31'd0, misroute_o}, {31'd0, mis_m});
      chk("nmi_o", {28'd0, nmi_o}, {28'd0, {NC{nmi_m}}});
      if (rst_ni) model_step();
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic req(input logic [3:0] lvl, input logic [7:0] cs, input logic [5:0] core);
      irq_i   = lvl;
      cause_i = cs;
      core_i  = core;
   endtask

   int d0;
   int r;

   initial begin
      for (int c = 0; c < NC; c++) begin
         deliv[c] = 0;
         off_m[c] = 1'b0;
      end
      #1 rst_ni = 1'b0;
      #1;
      chk("reset irq_o", {16'd0, irq_o}, 32'd0);
      chk("reset cause_o", cause_o, 32'd0);
      chk("reset flags", {27'd0, misroute_o, ovf_o}, 32'd0);
      step(3);

      // Held request: two-edge latency, exactly one delivery.
      rst_ni = 1'b1;
      req(4'd5, 8'h21, 6'd2);
      step(1);
      chk("latency edge1 irq2", {28'd0, irq_o[11:8]}, 32'd0);
      step(1);
      chk("offer irq2", {28'd0, irq_o[11:8]}, 32'd5);
      chk("offer cause2", {24'd0, cause_o[23:16]}, 32'h21);
      step(18);
      chk("held irq2", {28'd0, irq_o[11:8]}, 32'd5);
      d0 = deliv[2];
      ack_i[2] = 1'b1;
      step(1);
      ack_i[2] = 1'b0;
      chk("ack drops irq2", {28'd0, irq_o[11:8]}, 32'd0);
      step(5);
      chk("no reoffer irq2", {28'd0, irq_o[11:8]}, 32'd0);
      chk("one delivery core2", deliv[2] - d0, 32'd1);
      req(4'd0, 8'h00, 6'd0);

      // Masking and combinational ipl effect.
      ipl_i[7:4] = 4'd6;
      req(4'd4, 8'h44, 6'd1);
      step(2);
      chk("masked irq1", {28'd0, irq_o[7:4]}, 32'd0);
      chk("masked cause1", {24'd0, cause_o[15:8]}, 32'h44);
      ipl_i[7:4] = 4'd3;
      #1;
      chk("unmasked irq1", {28'd0, irq_o[7:4]}, 32'd4);
      ack_i[1] = 1'b1;
      step(1);
      ack_i[1] = 1'b0;
      ipl_i[7:4] = 4'd15;
      req(4'd15, 8'h55, 6'd1);
      step(2);
      chk("lvl15 at ipl15", {28'd0, irq_o[7:4]}, 32'd15);
      ack_i[1] = 1'b1;
      step(1);
      ack_i[1] = 1'b0;
      req(4'd0, 8'h00, 6'd0);
      ipl_i = '0;

      // Five requests into a depth-4 queue without acks.
      for (int i = 0; i < 5; i++) begin
         req(4'd2, 8'(8'h60 + i), 6'd0);
         step(1);
      end
      req(4'd0, 8'h00, 6'd0);
      step(1);
      chk("ovf core0", {31'd0, ovf_o[0]}, 32'd1);
      d0 = deliv[0];
      ack_i[0] = 1'b1;
      step(10);
      ack_i[0] = 1'b0;
      chk("four delivered core0", deliv[0] - d0, 32'd4);

      // Full queue with push and ack on the same edge.
      d0 = deliv[3];
      for (int i = 0; i < 5; i++) begin
         req(4'd3, 8'(8'h70 + i), 6'd3);
         if (i == 4) ack_i[3] = 1'b1;
         step(1);
      end
      ack_i[3] = 1'b0;
      req(4'd0, 8'h00, 6'd0);
      chk("no ovf core3", {31'd0, ovf_o[3]}, 32'd0);
      ack_i[3] = 1'b1;
      step(10);
      ack_i[3] = 1'b0;
      chk("five delivered core3", deliv[3] - d0, 32'd5);

      // Misrouted request and nmi fan-out.
      req(4'd3, 8'h99, 6'd9);
      step(2);
      chk("misroute irq0", {28'd0, irq_o[3:0]}, 32'd3);
      chk("misroute flag", {31'd0, misroute_o}, 32'd1);
      ack_i[0] = 1'b1;
      step(1);
      ack_i[0] = 1'b0;
      req(4'd0, 8'h00, 6'd0);
      nmi_i = 1'b1;
      #1;
      chk("nmi before edge", {28'd0, nmi_o}, 32'd0);
      step(1);
      chk("nmi rise", {28'd0, nmi_o}, 32'hF);
      nmi_i = 1'b0;
      step(1);
      chk("nmi fall", {28'd0, nmi_o}, 32'd0);

      // Reset while core 3 has entries queued and one offered.
      req(4'd7, 8'h81, 6'd3);
      step(1);
      req(4'd7, 8'h82, 6'd3);
      step(1);
      req(4'd7, 8'h83, 6'd3);
      step(1);
      rst_ni = 1'b0;
      #1;
      chk("midreset irq_o", {16'd0, irq_o}, 32'd0);
      chk("midreset cause_o", cause_o, 32'd0);
      chk("midreset flags", {27'd0, misroute_o, ovf_o}, 32'd0);
      step(2);
      rst_ni = 1'b1;
      step(1);
      chk("recapture edge1 irq3", {28'd0, irq_o[15:12]}, 32'd0);
      step(1);
      chk("recapture irq3", {28'd0, irq_o[15:12]}, 32'd7);
      chk("recapture cause3", {24'd0, cause_o[31:24]}, 32'h83);
      req(4'd0, 8'h00, 6'd0);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 15) begin
            irq_i = 4'd0;
         end else if (r < 45) begin
            irq_i   = 4'($urandom_range(1, 15));
            cause_i = 8'($urandom);
            core_i  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(NC, 63))
                                                  : 6'($urandom_range(0, NC - 1));
         end
         for (int c = 0; c < NC; c++) begin
            ack_i[c] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) ipl_i[4*c +: 4] = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 7) == 0) nmi_i = ~nmi_i;
         rst_ni = ($urandom_range(0, 999) != 0);
         step(1);
      end

      // Drain everything still queued.
      rst_ni = 1'b1;
      irq_i  = 4'd0;
      ipl_i  = '0;
      ack_i  = '1;
      step(20);
      for (int c = 0; c < NC; c++) begin
         chk($sformatf("drained core%0d", c), exp_q[c].size(), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/thor2023_irq_router.md
# thor2023_irq_router

Routes the single prioritized interrupt request produced by the PIC (level, cause code, target core) to per-core interrupt request ports. Each core gets a small pending queue with level masking and an acknowledge handshake. The block sits directly between the PIC outputs (irq level, cause, core select, nmi) and the irq/cause inputs of up to NCORES Thor2023 cores. Held PIC requests are converted into exactly-once deliveries.

## Interface
- NCORES, 4: number of target cores, 1..8.
- QDEPTH, 4: per-core pending-queue depth, power of two, 2..16.
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- irq_i  in  4  PIC irq level; 0 = no request.
- cause_i  in  8  PIC cause code.
- core_i  in  6  PIC target core.
- nmi_i  in  1  PIC nmi output.
- ipl_i  in  4*NCORES  current interrupt priority mask of each core; nibble c belongs to core c.
- ack_i  in  NCORES  core c accepts the request it is currently offered.
- irq_o  out  4*NCORES  offered irq level per core; 0 = none.
- cause_o  out  8*NCORES  offered cause per core.
- nmi_o  out  NCORES  nmi to every core.
- ovf_o  out  NCORES  sticky: a request for core c was dropped because its queue was full.
- misroute_o  out  1  sticky: a request named core_i >= NCORES.

## Operation
- **Capture.**
  - A request is new when irq_i != 0 and {irq_i, cause_i, core_i} differs from the last-captured tuple register (lt).
  - lt is loaded with every new request.
  - lt is cleared whenever irq_i == 0.
  - An unchanged, held PIC request is therefore pushed exactly once.
  - A request that drops and reasserts with the same tuple is pushed again.
- **Routing.**
  - Target is core_i when core_i < NCORES.
  - Otherwise the target is core 0 and misroute_o is set.
  - The request is pushed into the target's queue as {level, cause}.
- **Overflow.**
  - A push to a full queue is discarded and sets ovf_o[c].
  - Exception: if the same edge also pops that queue, the push succeeds.
- **Offer.**
  - Per core, a registered offer slot (state OFFER_IDLE / OFFER_VALID) holds the queue head.
  - In OFFER_IDLE with a non-empty queue, the head is loaded on the next edge and the state moves to OFFER_VALID.
  - **Masking (OFFER_VALID):**
    - irq_o[c] = level if level > ipl_i[c] or level == 15; otherwise irq_o[c] = 0.
    - cause_o[c] always shows the held cause.
    - A masked entry stays held and blocks the entries behind it (in-order delivery).
- **Acknowledge.**
  - ack_i[c] sampled high while irq_o[c] != 0 pops the head.
  - Offer returns to OFFER_IDLE and irq_o[c] goes 0 at that edge.
  - ack_i[c] while irq_o[c] == 0 is ignored.
- **NMI.** nmi_o[c] = registered nmi_i for all c. It is not queued and not masked.
- **Sticky clears.** ovf_o and misroute_o are cleared only by reset.
- **Reset (rst_ni low, at any time):**
  - queues empty, offers OFFER_IDLE, lt cleared.
  - All outputs 0: irq_o, cause_o, nmi_o, ovf_o, misroute_o.
  - Requests in flight are lost; the PIC reasserts held levels after reset, and these are captured as new.

## Timing
- PIC tuple sampled at edge N is in the queue after edge N.
- It is offered on irq_o/cause_o after edge N+1 when the queue was empty and the offer idle.
- Latency is therefore 2 edges.
- ack_i sampled at edge M:
  - irq_o[c] = 0 after M.
  - The next entry is offered after M+1.
  - There is a guaranteed one-cycle gap between deliveries, so a held ack cannot double-pop.
- nmi_o lags nmi_i by 1 edge.
- Change of ipl_i affects irq_o combinationally from the held slot (irq_o = slot level gated by compare). The slot register itself is unchanged.
- Simultaneous new request and ack on the same core: pop and push both happen at the same edge; queue count unchanged.
- Queue pointers wrap modulo QDEPTH. Count width is $clog2(QDEPTH)+1, and full means count == QDEPTH.

## Structure
- Package thor2023_irq_pkg:
  - irq_msg_t struct {level[3:0], cause[7:0]}.
  - offer_state_t enum {OFFER_IDLE, OFFER_VALID}.
  - Constant IRQ_LVL_NMI = 4'd15.
- Sub-module thor2023_irq_fifo:
  - parameterized synchronous FIFO of irq_msg_t.
  - push/pop/full/empty/head.
  - Async active-low reset.
  - One instance per core via generate.
- The top level holds capture, routing, offer slots and sticky flags.

## Test plan
- Reset check: hold rst_ni low → all outputs 0. Release, then irq_i=5, cause_i=8'h21, core_i=2 held 20 cycles → irq_o[2]=5, cause_o[2]=21 two edges later. Exactly one delivery after ack; no re-offer.
- Masking: ipl_i[1]=6 with level-4 request for core 1 → irq_o[1]=0 while cause_o[1]=cause. Lower ipl_i to 3 → irq_o[1]=4 the same cycle. Level 15 is delivered with ipl=15.
- Queue depth: 5 distinct requests to core 0 with no ack (QDEPTH=4) → first 4 delivered in order on successive acks. Fifth dropped; ovf_o[0]=1.
- Full queue with push and ack on the same edge → no drop; ovf_o stays 0.
- Routing: core_i=9 with NCORES=4 → delivered on core 0; misroute_o=1. Toggle nmi_i → all nmi_o follow 1 edge later.
- Reset mid-operation: rst_ni low while core 3 has 2 queued and 1 offered → outputs 0 immediately. After release with the PIC still holding level 7 → recaptured and offered after 2 edges.
